pong_frame_sequencer: RTL and testbench
=======================================

Name: pong_frame_sequencer

Overview:
- Registered game-state owner for pong; sits directly around the combinational pong step stage.
- Holds paddle positions, ball position/velocity and scores, and drives them into the step stage.
- On each frame tick, latches the step stage's next-state results.
- Sequences serve delay, play, point handling and game-over.

Parameters:
WIN_SCORE, 9, score value (4-bit) that ends the game; legal 1..15
SERVE_FRAMES, 30, frame ticks ball is held at centre before launch; legal 1..255
SERVE_VX, 2, signed 4-bit magnitude of launch x-velocity
SERVE_VY, 1, signed 4-bit launch y-velocity

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle strobe, one per game frame
start  in  1  one-cycle strobe; begins a new game from IDLE or OVER
pause  in  1  level; while high, frame_tick is ignored
step_paddle_1_pos, step_paddle_2_pos  in  8 signed  next paddle positions from step stage
step_ball_pos_x, step_ball_pos_y  in  8 signed  next ball position from step stage
step_ball_vel_x, step_ball_vel_y  in  4 signed  next ball velocity from step stage
step_score_p1, step_score_p2  in  4  next scores from step stage
paddle_1_pos, paddle_2_pos  out  8 signed  registered paddle positions (to step stage)
ball_pos_x, ball_pos_y  out  8 signed  registered ball position
ball_vel_x, ball_vel_y  out  4 signed  registered ball velocity
score_p1, score_p2  out  4  registered scores
state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3
step_en  out  1  combinational: frame_tick & !pause & (state==SERVE | state==PLAY)
game_over  out  1  state==OVER
winner  out  1  0 = p1 won, 1 = p2 won; valid while game_over

Behaviour:
- Reset (async): all position, velocity and score registers = 0; state = IDLE; serve counter = 0; serve_dir = 0; winner = 0.
- All updates occur only on rising clk; every output except step_en is registered.
- Step inputs are sampled in the same cycle step_en is high. Step inputs are ignored when step_en is low.
- IDLE:
  - start -> SERVE; scores := 0; ball := (0,0); vel := (0,0); counter := SERVE_FRAMES; serve_dir := 0.
  - frame_tick is ignored in IDLE, including when it coincides with start.
- SERVE, on step_en:
  - Paddles := step paddle values; ball remains (0,0) with vel (0,0); counter -= 1.
  - When the counter is 1 at the tick: state -> PLAY; ball_vel_x := serve_dir ? -SERVE_VX : +SERVE_VX; ball_vel_y := SERVE_VY.
  - Latency is exactly SERVE_FRAMES unpaused ticks from SERVE entry to PLAY.
- PLAY, on step_en:
  - Paddles, ball pos and ball vel := step values.
  - Point detection: a point occurs when step_score_p1 != score_p1 or step_score_p2 != score_p2.
  - If both scores change in the same tick, only the p1 change is taken; score_p2 is kept.
  - On a p1 point: score_p1 := step_score_p1; serve_dir := 0 (serve toward p2, +x).
  - On a p2 point: score_p2 := step_score_p2; serve_dir := 1 (serve toward p1, -x).
  - If the new score == WIN_SCORE: state -> OVER; winner set; ball and vel := 0.
  - Otherwise: state -> SERVE; ball := (0,0); vel := (0,0); counter := SERVE_FRAMES.
  - With no point, state stays PLAY.
- OVER:
  - All registers hold; frame_tick is ignored.
  - start -> SERVE with the same initialisation as from IDLE.
- start in SERVE or PLAY: ignored (no mid-game restart); only reset aborts a game.
- pause high: counter, positions and state all freeze; de-asserting resumes at the next frame_tick with no lost or extra tick.
- Score arithmetic is 4-bit and comes from the step stage; this block never increments a score itself. WIN_SCORE <= 15 guarantees the game ends before wrap.
- Reset asserted mid-frame forces IDLE immediately, regardless of state or pending tick.

Test Plan:
- Reset, then start, then 30 ticks with SERVE_FRAMES=30 -> state=1 through tick 29; tick 30 -> state=2, ball_vel_x=+2, ball_vel_y=+1, ball_pos=(0,0).
- In PLAY, drive step_ball_pos_x=10, step_ball_vel_x=-2 on a tick -> next cycle ball_pos_x=10, ball_vel_x=-2; same step values with frame_tick low -> no change.
- In PLAY, step_score_p2=score_p2+1 -> state=1, ball=(0,0), vel=0, score_p2 updated. After 30 ticks, ball_vel_x=-2 (serve toward p1).
- score_p1=8, WIN_SCORE=9, step_score_p1=9 -> state=3, game_over=1, winner=0. Ticks then ignored; start -> state=1 with scores=0.
- Both step scores incremented on the same tick -> only score_p1 changes; serve_dir=0.
- pause held for 5 ticks in SERVE with counter=3 -> counter stays 3 and step_en=0. Reset asserted asynchronously mid-PLAY -> state=0 and all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/pong_frame_sequencer.sv
// Registered game-state owner for pong: holds paddles, ball and scores around the
// combinational step stage and sequences serve, play, point handling and game-over.
module pong_frame_sequencer #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 30,
    parameter int SERVE_VX     = 2,
    parameter int SERVE_VY     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              pause,
    input  logic signed [7:0] step_paddle_1_pos,
    input  logic signed [7:0] step_paddle_2_pos,
    input  logic signed [7:0] step_ball_pos_x,
    input  logic signed [7:0] step_ball_pos_y,
    input  logic signed [3:0] step_ball_vel_x,
    input  logic signed [3:0] step_ball_vel_y,
    input  logic        [3:0] step_score_p1,
    input  logic        [3:0] step_score_p2,
    output logic signed [7:0] paddle_1_pos,
    output logic signed [7:0] paddle_2_pos,
    output logic signed [7:0] ball_pos_x,
    output logic signed [7:0] ball_pos_y,
    output logic signed [3:0] ball_vel_x,
    output logic signed [3:0] ball_vel_y,
    output logic        [3:0] score_p1,
    output logic        [3:0] score_p2,
    output logic        [1:0] state,
    output logic              step_en,
    output logic              game_over,
    output logic              winner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic signed [3:0] VX_POS     = 4'(SERVE_VX);
    localparam logic signed [3:0] VX_NEG     = 4'(-SERVE_VX);
    localparam logic signed [3:0] VY_SERVE   = 4'(SERVE_VY);
    localparam logic        [3:0] WIN_VALUE  = 4'(WIN_SCORE);
    localparam logic        [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);

    state_t            state_q, state_d;
    logic signed [7:0] paddle1_q, paddle1_d, paddle2_q, paddle2_d;
    logic signed [7:0] ballX_q, ballX_d, ballY_q, ballY_d;
    logic signed [3:0] velX_q, velX_d, velY_q, velY_d;
    logic        [3:0] score1_q, score1_d, score2_q, score2_d;
    logic        [7:0] counter_q, counter_d;
    logic              serveDir_q, serveDir_d;
    logic              winner_q, winner_d;
    logic              p1Point, p2Point;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            paddle1_q  <= '0;
            paddle2_q  <= '0;
            ballX_q    <= '0;
            ballY_q    <= '0;
            velX_q     <= '0;
            velY_q     <= '0;
            score1_q   <= '0;
            score2_q   <= '0;
            counter_q  <= '0;
            serveDir_q <= 1'b0;
            winner_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            paddle1_q  <= paddle1_d;
            paddle2_q  <= paddle2_d;
            ballX_q    <= ballX_d;
            ballY_q    <= ballY_d;
            velX_q     <= velX_d;
            velY_q     <= velY_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            counter_q  <= counter_d;
            serveDir_q <= serveDir_d;
            winner_q   <= winner_d;
        end
    end

    // A simultaneous change of both scores is credited to p1 only.
    assign p1Point = (step_score_p1 != score1_q);
    assign p2Point = (step_score_p2 != score2_q) && !p1Point;
    assign step_en = frame_tick && !pause && (state_q == SERVE || state_q == PLAY);

    always_comb begin
        state_d    = state_q;
        paddle1_d  = paddle1_q;
        paddle2_d  = paddle2_q;
        ballX_d    = ballX_q;
        ballY_d    = ballY_q;
        velX_d     = velX_q;
        velY_d     = velY_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        counter_d  = counter_q;
        serveDir_d = serveDir_q;
        winner_d   = winner_q;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d    = SERVE;
                    score1_d   = '0;
                    score2_d   = '0;
                    ballX_d    = '0;
                    ballY_d    = '0;
                    velX_d     = '0;
                    velY_d     = '0;
                    counter_d  = SERVE_LOAD;
                    serveDir_d = 1'b0;
                end
            end
            SERVE: begin
                if (step_en) begin
                    paddle1_d = step_paddle_1_pos;
                    paddle2_d = step_paddle_2_pos;
                    ballX_d   = '0;
                    ballY_d   = '0;
                    velX_d    = '0;
                    velY_d    = '0;
                    counter_d = counter_q - 8'd1;
                    if (counter_q == 8'd1) begin
                        state_d = PLAY;
                        velX_d  = serveDir_q ? VX_NEG : VX_POS;
                        velY_d  = VY_SERVE;
                    end
                end
            end
            PLAY: begin
                if (step_en) begin
                    paddle1_d = step_paddle_1_pos;
                    paddle2_d = step_paddle_2_pos;
                    ballX_d   = step_ball_pos_x;
                    ballY_d   = step_ball_pos_y;
                    velX_d    = step_ball_vel_x;
                    velY_d    = step_ball_vel_y;
                    if (p1Point || p2Point) begin
                        ballX_d = '0;
                        ballY_d = '0;
                        velX_d  = '0;
                        velY_d  = '0;
                        if (p1Point) begin
                            score1_d   = step_score_p1;
                            serveDir_d = 1'b0;
                        end else begin
                            score2_d   = step_score_p2;
                            serveDir_d = 1'b1;
                        end
                        if ((p1Point && step_score_p1 == WIN_VALUE) ||
                            (p2Point && step_score_p2 == WIN_VALUE)) begin
                            state_d  = OVER;
                            winner_d = p2Point;
                        end else begin
                            state_d   = SERVE;
                            counter_d = SERVE_LOAD;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign paddle_1_pos = paddle1_q;
    assign paddle_2_pos = paddle2_q;
    assign ball_pos_x   = ballX_q;
    assign ball_pos_y   = ballY_q;
    assign ball_vel_x   = velX_q;
    assign ball_vel_y   = velY_q;
    assign score_p1     = score1_q;
    assign score_p2     = score2_q;
    assign state        = state_q;
    assign game_over    = (state_q == OVER);
    assign winner       = winner_q;

endmodule

// File: tb/tb_pong_frame_sequencer.sv
// Directed self-checking bench for pong_frame_sequencer with default parameters
// (WIN_SCORE=9, SERVE_FRAMES=30, SERVE_VX=2, SERVE_VY=1).
module tb_pong_frame_sequencer;

    logic              clk = 1'b0;
    logic              reset, frameTick, start, pause;
    logic signed [7:0] stepPaddle1, stepPaddle2, stepBallX, stepBallY;
    logic signed [3:0] stepVelX, stepVelY;
    logic        [3:0] stepScore1, stepScore2;
    logic signed [7:0] paddle1, paddle2, ballX, ballY;
    logic signed [3:0] velX, velY;
    logic        [3:0] score1, score2;
    logic        [1:0] state;
    logic              stepEn, gameOver, winner;

    int vectors = 0;
    int miscompares = 0;

    pong_frame_sequencer dut (
        .clk(clk), .reset(reset), .frame_tick(frameTick), .start(start), .pause(pause),
        .step_paddle_1_pos(stepPaddle1), .step_paddle_2_pos(stepPaddle2),
        .step_ball_pos_x(stepBallX), .step_ball_pos_y(stepBallY),
        .step_ball_vel_x(stepVelX), .step_ball_vel_y(stepVelY),
        .step_score_p1(stepScore1), .step_score_p2(stepScore2),
        .paddle_1_pos(paddle1), .paddle_2_pos(paddle2),
        .ball_pos_x(ballX), .ball_pos_y(ballY),
        .ball_vel_x(velX), .ball_vel_y(velY),
        .score_p1(score1), .score_p2(score2),
        .state(state), .step_en(stepEn), .game_over(gameOver), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock cycle with the given frame_tick; outputs are stable 1 time unit after the edge.
    task automatic applyStimulus(input logic tick);
        frameTick = tick;
        @(posedge clk);
        #1;
        frameTick = 1'b0;
    endtask

    task automatic serveTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1);
    endtask

    task automatic pulseStart(input logic tick);
        start = 1'b1;
        applyStimulus(tick);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frameTick = 1'b0; start = 1'b0; pause = 1'b0;
        stepPaddle1 = 8'sd5; stepPaddle2 = -8'sd3;
        stepBallX = 8'sd7; stepBallY = 8'sd4;
        stepVelX = -4'sd1; stepVelY = 4'sd3;
        stepScore1 = 4'd0; stepScore2 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetState", state, 0);
        checkOutput("resetBallX", ballX, 0);
        checkOutput("resetPaddle1", paddle1, 0);
        checkOutput("resetGameOver", gameOver, 0);
        reset = 1'b0;

        applyStimulus(1'b1);
        checkOutput("idleTickIgnored", state, 0);
        checkOutput("idleStepEn", stepEn, 0);

        // start coinciding with a tick: tick must not step the paddles
        pulseStart(1'b1);
        checkOutput("startToServe", state, 1);
        checkOutput("startPaddleUntouched", paddle1, 0);

        for (int i = 1; i < 30; i++) begin
            applyStimulus(1'b1);
            checkOutput("serveHold", state, 1);
        end
        checkOutput("servePaddle1", paddle1, 5);
        checkOutput("servePaddle2", paddle2, -3);
        checkOutput("serveBallX", ballX, 0);
        checkOutput("serveVelX", velX, 0);
        applyStimulus(1'b1);
        checkOutput("launchState", state, 2);
        checkOutput("launchVelX", velX, 2);
        checkOutput("launchVelY", velY, 1);
        checkOutput("launchBallX", ballX, 0);
        checkOutput("launchBallY", ballY, 0);

        stepBallX = 8'sd10; stepVelX = -4'sd2;
        applyStimulus(1'b1);
        checkOutput("playBallX", ballX, 10);
        checkOutput("playBallY", ballY, 4);
        checkOutput("playVelX", velX, -2);
        stepBallX = 8'sd20; stepVelX = 4'sd3;
        repeat (3) applyStimulus(1'b0);
        checkOutput("noTickBallX", ballX, 10);
        checkOutput("noTickVelX", velX, -2);
        pause = 1'b1;
        applyStimulus(1'b1);
        checkOutput("pausedBallX", ballX, 10);
        pause = 1'b0;

        stepScore2 = 4'd1;
        applyStimulus(1'b1);
        checkOutput("p2PointState", state, 1);
        checkOutput("p2PointScore", score2, 1);
        checkOutput("p2PointBallX", ballX, 0);
        checkOutput("p2PointVelX", velX, 0);
        serveTicks(30);
        checkOutput("serveToP1State", state, 2);
        checkOutput("serveToP1VelX", velX, -2);

        stepScore1 = 4'd1; stepScore2 = 4'd2;
        applyStimulus(1'b1);
        checkOutput("bothScoreP1", score1, 1);
        checkOutput("bothScoreP2", score2, 1);
        checkOutput("bothState", state, 1);
        stepScore2 = 4'd1;
        serveTicks(30);
        checkOutput("serveToP2VelX", velX, 2);

        for (int k = 2; k <= 8; k++) begin
            stepScore1 = 4'(k);
            applyStimulus(1'b1);
            serveTicks(30);
        end
        checkOutput("p1At8", score1, 8);
        checkOutput("p1At8State", state, 2);
        stepScore1 = 4'd9;
        applyStimulus(1'b1);
        checkOutput("overState", state, 3);
        checkOutput("overGameOver", gameOver, 1);
        checkOutput("overWinner", winner, 0);
        checkOutput("overScore", score1, 9);
        checkOutput("overBallX", ballX, 0);

        stepScore1 = 4'd3; stepBallX = 8'sd55;
        applyStimulus(1'b1);
        checkOutput("overTickState", state, 3);
        checkOutput("overTickScore", score1, 9);
        checkOutput("overTickStepEn", stepEn, 0);

        stepScore1 = 4'd0; stepScore2 = 4'd0;
        pulseStart(1'b0);
        checkOutput("restartState", state, 1);
        checkOutput("restartScore1", score1, 0);
        checkOutput("restartScore2", score2, 0);
        checkOutput("restartGameOver", gameOver, 0);

        // 27 ticks leave 3 to go; pause must neither consume nor add ticks
        serveTicks(27);
        frameTick = 1'b1;
        #1;
        checkOutput("unpausedStepEn", stepEn, 1);
        frameTick = 1'b0;
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frameTick = 1'b1;
            #1;
            checkOutput("pauseStepEn", stepEn, 0);
            applyStimulus(1'b1);
        end
        pause = 1'b0;
        serveTicks(2);
        checkOutput("afterPauseServe", state, 1);
        applyStimulus(1'b1);
        checkOutput("afterPausePlay", state, 2);

        stepBallX = 8'sd10;
        applyStimulus(1'b1);
        checkOutput("preResetBallX", ballX, 10);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("asyncResetState", state, 0);
        checkOutput("asyncResetBallX", ballX, 0);
        checkOutput("asyncResetPaddle1", paddle1, 0);
        checkOutput("asyncResetVelX", velX, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        pulseStart(1'b0);
        for (int k = 1; k <= 9; k++) begin
            serveTicks(30);
            stepScore2 = 4'(k);
            applyStimulus(1'b1);
        end
        checkOutput("p2WinState", state, 3);
        checkOutput("p2WinWinner", winner, 1);
        checkOutput("p2WinScore", score2, 9);
        checkOutput("p2WinScoreP1", score1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
